// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 game-key decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_X      = 8'h22;
  localparam logic [7:0] SC_Z      = 8'h1A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_C      = 8'h21;
  localparam logic [7:0] SC_OVF_LO = 8'h00;
  localparam logic [7:0] SC_OVF_HI = 8'hFF;

  localparam int FRAME_BITS = 11;
  // Bytes that follow E1 in the Pause make sequence.
  localparam int PAUSE_SKIP = 7;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_UP    = 3;
  localparam int KEY_X     = 4;
  localparam int KEY_Z     = 5;
  localparam int KEY_SPACE = 6;
  localparam int KEY_C     = 7;
  localparam int KEY_COUNT = 8;

  // One-hot held-bit for a scancode; E0-prefixed codes only match with ext=1.
  function automatic logic [KEY_COUNT-1:0] key_mask(input logic [7:0] code, input logic ext);
    key_mask = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  key_mask[KEY_LEFT]  = 1'b1;
        SC_RIGHT: key_mask[KEY_RIGHT] = 1'b1;
        SC_DOWN:  key_mask[KEY_DOWN]  = 1'b1;
        SC_UP:    key_mask[KEY_UP]    = 1'b1;
        default:  key_mask = '0;
      endcase
    end else begin
      case (code)
        SC_X:     key_mask[KEY_X]     = 1'b1;
        SC_Z:     key_mask[KEY_Z]     = 1'b1;
        SC_SPACE: key_mask[KEY_SPACE] = 1'b1;
        SC_C:     key_mask[KEY_C]     = 1'b1;
        default:  key_mask = '0;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte stream from the PS/2 frame receiver to the scancode decoder.
interface ps2_key_decoder_if;
  // byte_valid and frame_err are single-cycle pushes with no backpressure:
  // the sink accepts every pulse; byte_data holds until the next byte_valid.
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  modport master (output byte_valid, output byte_data, output frame_err);
  modport slave  (input  byte_valid, input  byte_data, input  frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receive path: synchronizers, falling-edge detect, 11-bit frame check
// and inter-edge timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_key_decoder_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic [3:0]             bit_cnt;
  logic [8:0]             shift;
  logic [TW-1:0]          tcnt;
  logic                   fall;
  logic                   din;

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din  = data_sync[SYNC_STAGES-1];

  // Synchronizers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt        <= '0;
      shift          <= '0;
      tcnt           <= '0;
      bus.byte_valid <= 1'b0;
      bus.byte_data  <= '0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.byte_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (bit_cnt == '0) begin
          if (din) bus.frame_err <= 1'b1;
          else     bit_cnt <= 4'd1;
        end else if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          // shift holds d0..d7 then parity; odd parity makes the XOR 1
          if (din && (^shift)) begin
            bus.byte_valid <= 1'b1;
            bus.byte_data  <= shift[7:0];
          end else begin
            bus.frame_err <= 1'b1;
          end
        end else begin
          shift   <= {din, shift[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != '0) begin
        if (tcnt == TO_LAST) begin
          tcnt          <= '0;
          bit_cnt       <= '0;
          bus.frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 make/break decoder producing held levels for each game key.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       raw_left,
  output logic       raw_right,
  output logic       raw_down,
  output logic       raw_rotate_cw,
  output logic       raw_rotate_ccw,
  output logic       raw_drop,
  output logic       raw_hold,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output dec_state_t dbg_state
);

  ps2_key_decoder_if bus ();

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus)
  );

  dec_state_t           state, state_nxt;
  logic [2:0]           skip, skip_nxt;
  logic [KEY_COUNT-1:0] held, held_nxt;
  logic [7:0]           code;

  assign code = bus.byte_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      skip  <= '0;
      held  <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
      held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    held_nxt  = held;
    if (bus.frame_err) begin
      state_nxt = ST_IDLE;
      skip_nxt  = '0;
    end else if (bus.byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (code == SC_EXT) begin
            state_nxt = ST_EXT;
          end else if (code == SC_BRK) begin
            state_nxt = ST_BRK;
          end else if (code == SC_PAUSE) begin
            state_nxt = ST_SKIP;
            skip_nxt  = 3'(PAUSE_SKIP);
          end else if (code == SC_OVF_LO || code == SC_OVF_HI) begin
            held_nxt = '0;
          end else begin
            held_nxt = held | key_mask(code, 1'b0);
          end
        end
        ST_EXT: begin
          if (code == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else if (code != SC_EXT) begin
            held_nxt  = held | key_mask(code, 1'b1);
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          held_nxt  = held & ~key_mask(code, 1'b0);
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          held_nxt  = held & ~key_mask(code, 1'b1);
          state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          skip_nxt = skip - 3'd1;
          if (skip == 3'd1) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign raw_left       = held[KEY_LEFT];
  assign raw_right      = held[KEY_RIGHT];
  assign raw_down       = held[KEY_DOWN];
  // Up and X are tracked separately so releasing one keeps rotation held.
  assign raw_rotate_cw  = held[KEY_UP] | held[KEY_X];
  assign raw_rotate_ccw = held[KEY_Z];
  assign raw_drop       = held[KEY_SPACE];
  assign raw_hold       = held[KEY_C];
  assign byte_valid     = bus.byte_valid;
  assign byte_data      = bus.byte_data;
  assign frame_err      = bus.frame_err;
  assign dbg_state      = state;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table vectors, hand sequences and
// random byte streams against a scancode-level reference model.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 20;

  // ---------------- clock / reset ----------------
  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic raw_left, raw_right, raw_down, raw_rotate_cw, raw_rotate_ccw, raw_drop, raw_hold;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  dec_state_t dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_key_decoder_if mon ();
  assign mon.byte_valid = byte_valid;
  assign mon.byte_data  = byte_data;
  assign mon.frame_err  = frame_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .raw_left(raw_left), .raw_right(raw_right), .raw_down(raw_down),
    .raw_rotate_cw(raw_rotate_cw), .raw_rotate_ccw(raw_rotate_ccw),
    .raw_drop(raw_drop), .raw_hold(raw_hold),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // {left, right, down, rotate_cw, rotate_ccw, drop, hold}
  function automatic logic [6:0] keys_now();
    return {raw_left, raw_right, raw_down, raw_rotate_cw, raw_rotate_ccw, raw_drop, raw_hold};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int         n_valid = 0;
  int         n_err   = 0;
  int         vcyc_q[$];
  int         ecyc_q[$];
  int         left_chg_cyc[$];
  logic       left_chg_val[$];
  int         other_toggles = 0;
  logic [6:0] prev_keys = '0;
  int         last_fall = 0;

  always @(negedge clk) begin
    logic [6:0] cur;
    cur = keys_now();
    if (mon.byte_valid) begin
      n_valid++;
      vcyc_q.push_back(cyc);
      check("byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("byte_data", mon.byte_data, exp_q.pop_front());
    end
    if (mon.frame_err) begin
      n_err++;
      ecyc_q.push_back(cyc);
    end
    if (cur[6] != prev_keys[6]) begin
      left_chg_cyc.push_back(cyc);
      left_chg_val.push_back(cur[6]);
    end
    other_toggles += $countones(cur[5:0] ^ prev_keys[5:0]);
    prev_keys = cur;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] code;
    bit         ext;
  } keymap_t;
  keymap_t    kmap[8];
  logic [7:0] m_held;
  bit         m_ext, m_brk;
  int         m_skip;

  function automatic int key_index(input logic [7:0] code, input bit ext);
    for (int i = 0; i < 8; i++)
      if (kmap[i].code == code && kmap[i].ext == ext) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_held = '0; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_err();
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (m_skip > 0) begin m_skip--; return; end
    if (!m_brk && b == 8'hE0) begin m_ext = 1; return; end
    if (!m_brk && b == 8'hF0) begin m_brk = 1; return; end
    if (!m_ext && !m_brk && b == 8'hE1) begin m_skip = 7; return; end
    if (!m_ext && !m_brk && (b == 8'h00 || b == 8'hFF)) begin m_held = '0; return; end
    k = key_index(b, m_ext);
    if (k >= 0) m_held[k] = !m_brk;
    m_ext = 0;
    m_brk = 0;
  endtask

  function automatic logic [6:0] model_keys();
    return {m_held[0], m_held[1], m_held[2], m_held[3] | m_held[4], m_held[5], m_held[6], m_held[7]};
  endfunction

  // ---------------- drivers ----------------
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    bits = frame_bits(b, bad_par);
    if (bad_par) model_err();
    else begin
      exp_q.push_back(b);
      model_byte(b);
    end
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] b;
    bit         bad;
    logic [6:0] keys;
    bit         idle;
  } vec_t;
  vec_t vt[$];

  task automatic add_vec(input logic [7:0] b, input bit bad, input logic [6:0] keys, input bit idle);
    vec_t v;
    v.b = b; v.bad = bad; v.keys = keys; v.idle = idle;
    vt.push_back(v);
  endtask

  logic [7:0] pool[14];

  initial begin
    int e0, v0, d;
    logic [10:0] bits;
    logic [7:0]  rb;
    bit          rbad;

    kmap[0] = '{8'h6B, 1'b1}; kmap[1] = '{8'h74, 1'b1};
    kmap[2] = '{8'h72, 1'b1}; kmap[3] = '{8'h75, 1'b1};
    kmap[4] = '{8'h22, 1'b0}; kmap[5] = '{8'h1A, 1'b0};
    kmap[6] = '{8'h29, 1'b0}; kmap[7] = '{8'h21, 1'b0};
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h6B, 8'h74, 8'h72, 8'h75,
             8'h22, 8'h1A, 8'h29, 8'h21, 8'h00, 8'hFF, 8'hFA};
    model_reset();

    // reset state
    repeat (4) @(negedge clk);
    check("reset_keys", keys_now(), 7'h00);
    check("reset_byte_valid", byte_valid, 0);
    check("reset_byte_data", byte_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // left arrow make, idle gap, break; check one-clock key latency
    vcyc_q.delete(); left_chg_cyc.delete(); left_chg_val.delete(); other_toggles = 0;
    send_frame(8'hE0, 0);
    send_frame(8'h6B, 0);
    repeat (12) @(negedge clk);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h6B, 0);
    check("t1_valid_count", vcyc_q.size(), 5);
    check("t1_left_edges", left_chg_cyc.size(), 2);
    if (vcyc_q.size() == 5 && left_chg_cyc.size() == 2) begin
      check("t1_rise_delay", left_chg_cyc[0] - vcyc_q[1], 1);
      check("t1_rise_value", left_chg_val[0], 1);
      check("t1_fall_delay", left_chg_cyc[1] - vcyc_q[4], 1);
      check("t1_fall_value", left_chg_val[1], 0);
    end
    check("t1_other_toggles", other_toggles, 0);

    // table: keys are {left,right,down,cw,ccw,drop,hold}
    add_vec(8'h29, 0, 7'h02, 1); add_vec(8'hE0, 0, 7'h02, 0);
    add_vec(8'h74, 0, 7'h22, 1); add_vec(8'hF0, 0, 7'h22, 0);
    add_vec(8'h29, 0, 7'h20, 1); add_vec(8'hE0, 0, 7'h20, 0);
    add_vec(8'hF0, 0, 7'h20, 0); add_vec(8'h74, 0, 7'h00, 1);
    add_vec(8'h6B, 1, 7'h00, 1); add_vec(8'h1A, 0, 7'h04, 1);
    add_vec(8'hF0, 0, 7'h04, 0); add_vec(8'h1A, 0, 7'h00, 1);
    add_vec(8'hE0, 0, 7'h00, 0); add_vec(8'h6B, 1, 7'h00, 1);
    add_vec(8'h6B, 0, 7'h00, 1);
    add_vec(8'hE1, 0, 7'h00, 0); add_vec(8'h14, 0, 7'h00, 0);
    add_vec(8'h77, 0, 7'h00, 0); add_vec(8'hE1, 0, 7'h00, 0);
    add_vec(8'hF0, 0, 7'h00, 0); add_vec(8'h14, 0, 7'h00, 0);
    add_vec(8'hF0, 0, 7'h00, 0); add_vec(8'h77, 0, 7'h00, 1);
    add_vec(8'h21, 0, 7'h01, 1); add_vec(8'h22, 0, 7'h09, 1);
    add_vec(8'hFA, 0, 7'h09, 1); add_vec(8'h29, 0, 7'h0B, 1);
    add_vec(8'h29, 0, 7'h0B, 1); add_vec(8'h00, 0, 7'h00, 1);
    add_vec(8'hE0, 0, 7'h00, 0); add_vec(8'h75, 0, 7'h08, 1);
    add_vec(8'hFF, 0, 7'h00, 1);
    foreach (vt[i]) begin
      e0 = n_err; v0 = n_valid;
      send_frame(vt[i].b, vt[i].bad);
      check($sformatf("vec%0d_keys", i), keys_now(), vt[i].keys);
      check($sformatf("vec%0d_err", i), n_err - e0, vt[i].bad ? 1 : 0);
      check($sformatf("vec%0d_valid", i), n_valid - v0, vt[i].bad ? 0 : 1);
      if (vt[i].idle) check($sformatf("vec%0d_state", i), dbg_state, ST_IDLE);
    end

    // partial frame then silence: timeout discards it, receiver recovers
    e0 = n_err; v0 = n_valid; ecyc_q.delete();
    bits = frame_bits(8'h75, 0);
    for (int i = 0; i < 5; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 20) @(negedge clk);
    model_err();
    check("t4_err_count", n_err - e0, 1);
    check("t4_no_byte", n_valid - v0, 0);
    if (ecyc_q.size() > 0) begin
      d = ecyc_q[0] - last_fall;
      check("t4_timeout_latency", d, TIMEOUT + 3);
    end
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    check("t4_rotate_cw", keys_now(), 7'h08);

    // hold Up and X, release X, then reset mid-frame
    send_frame(8'h22, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h22, 0);
    check("t6_cw_after_x_break", keys_now(), 7'h08);
    bits = frame_bits(8'h22, 0);
    for (int i = 0; i < 5; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_keys", keys_now(), 7'h00);
    check("t6_rst_byte_valid", byte_valid, 0);
    check("t6_rst_byte_data", byte_data, 0);
    check("t6_rst_frame_err", frame_err, 0);
    check("t6_rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    model_reset();
    e0 = n_err;
    repeat (TIMEOUT + 20) @(negedge clk);
    check("t6_no_stale_timeout", n_err - e0, 0);
    send_frame(8'h22, 0);
    check("t6_cw_after_reset", keys_now(), 7'h08);

    // random streams against the model
    for (int i = 0; i < 50; i++) begin
      int idx;
      idx  = $urandom_range(0, 15);
      rb   = (idx >= 14) ? 8'($urandom_range(0, 255)) : pool[idx];
      rbad = ($urandom_range(0, 99) < 8);
      e0 = n_err;
      send_frame(rb, rbad);
      check($sformatf("rand%0d_keys_b%02h", i, rb), keys_now(), model_keys());
      check($sformatf("rand%0d_err", i), n_err - e0, rbad ? 1 : 0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
